// File: rtl/seq_to_sim_reg_ps_last_opt.sv
// Serial-in, parallel-out register bank: collects SHIFT_LEN words and shows them all at once.
// With PASSING_LAST=1 the newest slot is taken straight from `in`, so one register stage is not built.
module seq_to_sim_reg_ps_last_opt #(
  parameter string OUTTER_MODULE = "",
  parameter string MODULE_NAME   = "",
  parameter int    DIRECTION     = 1,
  parameter int    SHIFT_LEN     = 8,
  parameter int    BIT_WIDTH     = 40,
  parameter int    PASSING_LAST  = 0
) (
  input  logic                           clk,
  input  logic                           in_ctr_Srst,
  input  logic                           in_ctr_en,
  input  logic [0:0]                     in_ctr_sig,
  input  logic [BIT_WIDTH-1:0]           in,
  output logic [SHIFT_LEN*BIT_WIDTH-1:0] out
);

  localparam int REGS = SHIFT_LEN - PASSING_LAST;
  localparam bit FWD  = (DIRECTION > 0);
  localparam bit PL   = (PASSING_LAST != 0);

  if (SHIFT_LEN < 1 || BIT_WIDTH < 1) begin : g_bad_param
    $error("%s/%s: SHIFT_LEN (%0d) and BIT_WIDTH (%0d) must both be >= 1",
           OUTTER_MODULE, MODULE_NAME, SHIFT_LEN, BIT_WIDTH);
  end else begin : g_param_info
    $info("%s/%s: DIRECTION=%0d SHIFT_LEN=%0d BIT_WIDTH=%0d PASSING_LAST=%0d",
          OUTTER_MODULE, MODULE_NAME, DIRECTION, SHIFT_LEN, BIT_WIDTH, PASSING_LAST);
  end

  if (REGS < 1) begin : g_passthru
    // Single passing slot: no state, so clock, reset and enables are irrelevant.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, in_ctr_Srst, in_ctr_en, in_ctr_sig};
    assign out = in;
  end else begin : g_regs
    logic [REGS-1:0][BIT_WIDTH-1:0] regs_q;
    logic [REGS-1:0][BIT_WIDTH-1:0] regs_d;

    // Forward: enter at the top register and move down; reverse: enter at register 0 and move up.
    always_comb begin
      regs_d = regs_q;
      if (in_ctr_en && in_ctr_sig[0]) begin
        if (FWD) begin
          for (int i = 0; i < REGS - 1; i++) begin
            regs_d[i] = regs_q[i + 1];
          end
          regs_d[REGS-1] = in;
        end else begin
          for (int i = 1; i < REGS; i++) begin
            regs_d[i] = regs_q[i - 1];
          end
          regs_d[0] = in;
        end
      end
    end

    always_ff @(posedge clk or posedge in_ctr_Srst) begin
      if (in_ctr_Srst) begin
        regs_q <= '0;
      end else begin
        regs_q <= regs_d;
      end
    end

    // The passing slot sits above the registers going forward, below them in reverse.
    if (PL && FWD) begin : g_out_fwd_pl
      assign out = {in, regs_q};
    end else if (PL) begin : g_out_rev_pl
      assign out = {regs_q, in};
    end else begin : g_out_all_reg
      assign out = regs_q;
    end
  end

endmodule

// File: tb/tb_seq_to_sim_reg_ps_last_opt.sv
// Bench for seq_to_sim_reg_ps_last_opt: eight configurations share one stimulus stream
// and are checked against a history-queue model of the slot contents.
module tb_seq_to_sim_reg_ps_last_opt;

  localparam int NDUT = 8;
  localparam int S_TAB  [NDUT] = '{4, 4, 4, 4, 4, 1, 8, 8};
  localparam int BW_TAB [NDUT] = '{8, 8, 8, 8, 8, 8, 40, 40};
  localparam bit FWD_TAB[NDUT] = '{1, 0, 0, 1, 0, 1, 1, 0};
  localparam bit PL_TAB [NDUT] = '{0, 0, 0, 1, 1, 1, 0, 1};

  logic        clk;
  logic        rst;
  logic        en;
  logic [0:0]  sig;
  logic [39:0] in_w;

  logic [31:0]  out0, out1, out2, out3, out4;
  logic [7:0]   out5;
  logic [319:0] out6, out7;
  logic [319:0] act [NDUT];

  int n_vec;
  int n_err;
  logic [39:0] hist[$];

  seq_to_sim_reg_ps_last_opt #(.OUTTER_MODULE("tb"), .MODULE_NAME("fwd"), .DIRECTION(1),
    .SHIFT_LEN(4), .BIT_WIDTH(8), .PASSING_LAST(0)) u_fwd (.clk(clk), .in_ctr_Srst(rst),
    .in_ctr_en(en), .in_ctr_sig(sig), .in(in_w[7:0]), .out(out0));
  seq_to_sim_reg_ps_last_opt #(.OUTTER_MODULE("tb"), .MODULE_NAME("rev_m1"), .DIRECTION(-1),
    .SHIFT_LEN(4), .BIT_WIDTH(8), .PASSING_LAST(0)) u_rev_m1 (.clk(clk), .in_ctr_Srst(rst),
    .in_ctr_en(en), .in_ctr_sig(sig), .in(in_w[7:0]), .out(out1));
  seq_to_sim_reg_ps_last_opt #(.OUTTER_MODULE("tb"), .MODULE_NAME("rev_0"), .DIRECTION(0),
    .SHIFT_LEN(4), .BIT_WIDTH(8), .PASSING_LAST(0)) u_rev_0 (.clk(clk), .in_ctr_Srst(rst),
    .in_ctr_en(en), .in_ctr_sig(sig), .in(in_w[7:0]), .out(out2));
  seq_to_sim_reg_ps_last_opt #(.OUTTER_MODULE("tb"), .MODULE_NAME("fwd_pl"), .DIRECTION(1),
    .SHIFT_LEN(4), .BIT_WIDTH(8), .PASSING_LAST(1)) u_fwd_pl (.clk(clk), .in_ctr_Srst(rst),
    .in_ctr_en(en), .in_ctr_sig(sig), .in(in_w[7:0]), .out(out3));
  seq_to_sim_reg_ps_last_opt #(.OUTTER_MODULE("tb"), .MODULE_NAME("rev_pl"), .DIRECTION(-1),
    .SHIFT_LEN(4), .BIT_WIDTH(8), .PASSING_LAST(1)) u_rev_pl (.clk(clk), .in_ctr_Srst(rst),
    .in_ctr_en(en), .in_ctr_sig(sig), .in(in_w[7:0]), .out(out4));
  seq_to_sim_reg_ps_last_opt #(.OUTTER_MODULE("tb"), .MODULE_NAME("degen"), .DIRECTION(1),
    .SHIFT_LEN(1), .BIT_WIDTH(8), .PASSING_LAST(1)) u_degen (.clk(clk), .in_ctr_Srst(rst),
    .in_ctr_en(en), .in_ctr_sig(sig), .in(in_w[7:0]), .out(out5));
  seq_to_sim_reg_ps_last_opt #(.OUTTER_MODULE("tb"), .MODULE_NAME("wide_fwd"), .DIRECTION(1),
    .SHIFT_LEN(8), .BIT_WIDTH(40), .PASSING_LAST(0)) u_wide_fwd (.clk(clk), .in_ctr_Srst(rst),
    .in_ctr_en(en), .in_ctr_sig(sig), .in(in_w), .out(out6));
  seq_to_sim_reg_ps_last_opt #(.OUTTER_MODULE("tb"), .MODULE_NAME("wide_rev_pl"), .DIRECTION(0),
    .SHIFT_LEN(8), .BIT_WIDTH(40), .PASSING_LAST(1)) u_wide_rev_pl (.clk(clk), .in_ctr_Srst(rst),
    .in_ctr_en(en), .in_ctr_sig(sig), .in(in_w), .out(out7));

  assign act[0] = 320'(out0);
  assign act[1] = 320'(out1);
  assign act[2] = 320'(out2);
  assign act[3] = 320'(out3);
  assign act[4] = 320'(out4);
  assign act[5] = 320'(out5);
  assign act[6] = out6;
  assign act[7] = out7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slot k from the list of accepted words: forward puts the newest at the top, reverse at slot 0.
  function automatic logic [319:0] model_out(int d);
    int s, bw, r, n, idx;
    logic [39:0]  mask, w;
    logic [319:0] res;
    s    = S_TAB[d];
    bw   = BW_TAB[d];
    r    = s - (PL_TAB[d] ? 1 : 0);
    n    = hist.size();
    mask = {40{1'b1}} >> (40 - bw);
    res  = '0;
    for (int k = 0; k < s; k++) begin
      if (PL_TAB[d] && ((FWD_TAB[d] && k == s - 1) || (!FWD_TAB[d] && k == 0))) begin
        w = in_w;
      end else begin
        if (FWD_TAB[d]) idx = n - r + k;
        else            idx = n - 1 - (PL_TAB[d] ? k - 1 : k);
        w = (idx >= 0) ? hist[idx] : 40'h0;
      end
      res = res | (320'(w & mask) << (k * bw));
    end
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst && en && sig[0]) begin
      hist.push_back(in_w);
      if (hist.size() > 16) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic shift_word(input logic [39:0] w);
    in_w = w;
    en   = 1'b1;
    sig  = 1'b1;
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    hist.delete();
    #2;
    rst = 1'b0;
    en  = 1'b0;
    sig = 1'b0;
  endtask

  task automatic test_reset();
    logic [319:0] e;
    rst  = 1'b1;
    en   = 1'b0;
    sig  = 1'b0;
    in_w = 40'h12_3456_789A;
    hist.delete();
    #3;
    for (int d = 0; d < NDUT; d++) begin
      e = model_out(d);
      n_vec++;
      if (act[d] !== e) begin
        n_err++;
        $display("FAIL reset dut%0d: got %h expected %h", d, act[d], e);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_forward_reverse();
    logic [319:0] e;
    do_reset();
    shift_word(40'h11);
    shift_word(40'h22);
    shift_word(40'h33);
    shift_word(40'h44);
    n_vec += 3;
    if (out0 !== 32'h44332211) begin
      n_err++; $display("FAIL fwd4: got %h expected 44332211", out0);
    end
    if (out1 !== 32'h11223344) begin
      n_err++; $display("FAIL rev_m1_4: got %h expected 11223344", out1);
    end
    if (out2 !== 32'h11223344) begin
      n_err++; $display("FAIL rev_0_4: got %h expected 11223344", out2);
    end
    shift_word(40'h55);
    n_vec++;
    if (out0 !== 32'h55443322) begin
      n_err++; $display("FAIL fwd5: got %h expected 55443322", out0);
    end
    for (int d = 0; d < NDUT; d++) begin
      e = model_out(d);
      n_vec++;
      if (act[d] !== e) begin
        n_err++;
        $display("FAIL fwd_rev_model dut%0d: got %h expected %h", d, act[d], e);
      end
    end
  endtask

  task automatic test_enable_gating();
    do_reset();
    shift_word(40'h11);
    shift_word(40'h22);
    shift_word(40'h33);
    shift_word(40'h44);
    in_w = 40'hAA;
    for (int ph = 0; ph < 2; ph++) begin
      en  = (ph == 1) ? 1'b0 : 1'b1;
      sig = (ph == 1) ? 1'b1 : 1'b0;
      for (int c = 0; c < 3; c++) begin
        step();
        n_vec++;
        if (out0 !== 32'h44332211) begin
          n_err++;
          $display("FAIL gate ph%0d c%0d: got %h expected 44332211", ph, c, out0);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [319:0] e;
    do_reset();
    shift_word(40'h11);
    shift_word(40'h22);
    @(negedge clk);
    #2;
    rst = 1'b1;
    hist.delete();
    #1;
    n_vec++;
    if (out0 !== 32'h0) begin
      n_err++; $display("FAIL async_rst fwd: got %h expected 00000000", out0);
    end
    for (int d = 0; d < NDUT; d++) begin
      e = model_out(d);
      n_vec++;
      if (act[d] !== e) begin
        n_err++;
        $display("FAIL async_rst dut%0d: got %h expected %h", d, act[d], e);
      end
    end
    #1;
    rst = 1'b0;
    shift_word(40'h11);
    shift_word(40'h22);
    n_vec++;
    if (out0 !== 32'h22110000) begin
      n_err++; $display("FAIL after_rst fwd: got %h expected 22110000", out0);
    end
  endtask

  task automatic test_passing_last();
    do_reset();
    shift_word(40'h11);
    shift_word(40'h22);
    shift_word(40'h33);
    en   = 1'b0;
    sig  = 1'b0;
    in_w = 40'h44;
    #1;
    n_vec += 2;
    if (out3 !== 32'h44332211) begin
      n_err++; $display("FAIL pl_fwd: got %h expected 44332211", out3);
    end
    if (out4 !== 32'h11223344) begin
      n_err++; $display("FAIL pl_rev: got %h expected 11223344", out4);
    end
    in_w = 40'h99;
    #1;
    n_vec += 2;
    if (out3 !== 32'h99332211) begin
      n_err++; $display("FAIL pl_fwd_in: got %h expected 99332211", out3);
    end
    if (out4 !== 32'h11223399) begin
      n_err++; $display("FAIL pl_rev_in: got %h expected 11223399", out4);
    end
  endtask

  task automatic test_degenerate();
    in_w = 40'h5A;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rst = 1'($urandom_range(0, 1));
      en  = 1'($urandom_range(0, 1));
      sig = 1'($urandom_range(0, 1));
      #1;
      n_vec++;
      if (out5 !== 8'h5A) begin
        n_err++; $display("FAIL degen c%0d: got %h expected 5a", c, out5);
      end
    end
    rst = 1'b0;
    hist.delete();
    in_w = 40'($urandom_range(0, 255));
    #1;
    n_vec++;
    if (out5 !== in_w[7:0]) begin
      n_err++; $display("FAIL degen_in: got %h expected %h", out5, in_w[7:0]);
    end
  endtask

  task automatic test_random();
    logic [319:0] e;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      in_w = {8'($urandom), 32'($urandom)};
      en   = ($urandom_range(0, 9) != 0);
      sig  = 1'($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 39) == 0);
      if (rst) hist.delete();
      #1;
      for (int d = 0; d < NDUT; d++) begin
        e = model_out(d);
        n_vec++;
        if (act[d] !== e) begin
          n_err++;
          $display("FAIL random c%0d dut%0d: got %h expected %h", c, d, act[d], e);
        end
      end
      step();
      if (rst) begin
        rst = 1'b0;
        hist.delete();
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_forward_reverse();
    test_enable_gating();
    test_async_reset();
    test_passing_last();
    test_degenerate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
